// File: rtl/led_pwm_multi_driver.sv
// Multi-channel LED PWM driver: a shared prescaler and a 255-step period counter,
// shadow registers loaded only at period boundaries, and a fixed phase stagger per LED index.
module led_pwm_multi_driver #(
   parameter int parm_color_led_count = 4,
   parameter int parm_basic_led_count = 4,
   parameter int parm_FCLK            = 40_000_000,
   parameter int parm_pwm_freq        = 1_000,
   parameter int parm_phase_step      = 64
) (
   input  logic                              i_clk,
   input  logic                              i_srst_n,
   input  logic [8*parm_color_led_count-1:0] i_color_led_red_value,
   input  logic [8*parm_color_led_count-1:0] i_color_led_green_value,
   input  logic [8*parm_color_led_count-1:0] i_color_led_blue_value,
   input  logic [8*parm_basic_led_count-1:0] i_basic_led_lumin_value,
   output logic [parm_color_led_count-1:0]   o_color_led_red,
   output logic [parm_color_led_count-1:0]   o_color_led_green,
   output logic [parm_color_led_count-1:0]   o_color_led_blue,
   output logic [parm_basic_led_count-1:0]   o_basic_led_lumin,
   output logic                              o_period_strobe
);

   localparam int c_n          = parm_color_led_count;
   localparam int c_m          = parm_basic_led_count;
   localparam int c_tick_div   = parm_FCLK / (parm_pwm_freq * 255);
   localparam int c_pre_w      = (c_tick_div > 1) ? $clog2(c_tick_div) : 1;
   localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(c_tick_div - 1);
   localparam logic [7:0]         c_cnt_last = 8'd254;

   logic [c_pre_w-1:0] presc_q, presc_d;
   logic [7:0]         count_q, count_d;
   logic               tick;
   logic               load;
   logic               strobe_q;

   logic [8*c_n-1:0] red_sh_q, grn_sh_q, blu_sh_q;
   logic [8*c_m-1:0] lum_sh_q;

   logic [c_n-1:0] red_pin_q, grn_pin_q, blu_pin_q;
   logic [c_n-1:0] red_pin_d, grn_pin_d, blu_pin_d;
   logic [c_m-1:0] lum_pin_q, lum_pin_d;

   // Staggered position of a channel inside the 255-tick period, range 0..254.
   function automatic logic [8:0] eff_count(input logic [7:0] cnt, input logic [7:0] off);
      logic [8:0] s;
      s = {1'b0, cnt} + {1'b0, off};
      if (s >= 9'd255) begin
         s = s - 9'd255;
      end
      return s;
   endfunction

   always_comb begin
      tick    = (presc_q == c_pre_max);
      presc_d = tick ? '0 : presc_q + 1'b1;
      load    = tick && (count_q == c_cnt_last);
      count_d = count_q;
      if (tick) begin
         count_d = (count_q == c_cnt_last) ? 8'd0 : count_q + 8'd1;
      end
   end

   always_comb begin
      logic [8:0] e;
      red_pin_d = '0;
      grn_pin_d = '0;
      blu_pin_d = '0;
      lum_pin_d = '0;
      e         = '0;
      for (int k = 0; k < c_n; k++) begin
         e = eff_count(count_q, 8'((k * parm_phase_step) % 255));
         red_pin_d[k] = (e < {1'b0, red_sh_q[8*k +: 8]});
         grn_pin_d[k] = (e < {1'b0, grn_sh_q[8*k +: 8]});
         blu_pin_d[k] = (e < {1'b0, blu_sh_q[8*k +: 8]});
      end
      for (int k = 0; k < c_m; k++) begin
         e = eff_count(count_q, 8'((k * parm_phase_step) % 255));
         lum_pin_d[k] = (e < {1'b0, lum_sh_q[8*k +: 8]});
      end
   end

   // Count parks at 254 in reset so the first tick afterwards loads shadows and opens period 0.
   always_ff @(posedge i_clk) begin
      if (!i_srst_n) begin
         presc_q   <= '0;
         count_q   <= c_cnt_last;
         strobe_q  <= 1'b0;
         red_sh_q  <= '0;
         grn_sh_q  <= '0;
         blu_sh_q  <= '0;
         lum_sh_q  <= '0;
         red_pin_q <= '0;
         grn_pin_q <= '0;
         blu_pin_q <= '0;
         lum_pin_q <= '0;
      end else begin
         presc_q   <= presc_d;
         count_q   <= count_d;
         strobe_q  <= load;
         red_pin_q <= red_pin_d;
         grn_pin_q <= grn_pin_d;
         blu_pin_q <= blu_pin_d;
         lum_pin_q <= lum_pin_d;
         if (load) begin
            red_sh_q <= i_color_led_red_value;
            grn_sh_q <= i_color_led_green_value;
            blu_sh_q <= i_color_led_blue_value;
            lum_sh_q <= i_basic_led_lumin_value;
         end
      end
   end

   assign o_color_led_red   = red_pin_q;
   assign o_color_led_green = grn_pin_q;
   assign o_color_led_blue  = blu_pin_q;
   assign o_basic_led_lumin = lum_pin_q;
   assign o_period_strobe   = strobe_q;

endmodule

// File: tb/tb_led_pwm_multi_driver.sv
// Bench for led_pwm_multi_driver: two instances (no stagger / stagger 64) checked every clock
// against a tick-arithmetic reference model, plus measured high times per period.
module tb_led_pwm_multi_driver;

   logic        clk = 1'b0;
   logic        srst_n;
   logic [31:0] red, grn, blu, bas;
   logic [3:0]  r0, g0, b0, l0, r1, g1, b1, l1;
   logic        st0, st1;

   always #5 clk = ~clk;

   led_pwm_multi_driver #(
      .parm_color_led_count(4), .parm_basic_led_count(4),
      .parm_FCLK(2550), .parm_pwm_freq(1), .parm_phase_step(0)
   ) u_dut0 (
      .i_clk(clk), .i_srst_n(srst_n),
      .i_color_led_red_value(red), .i_color_led_green_value(grn),
      .i_color_led_blue_value(blu), .i_basic_led_lumin_value(bas),
      .o_color_led_red(r0), .o_color_led_green(g0), .o_color_led_blue(b0),
      .o_basic_led_lumin(l0), .o_period_strobe(st0)
   );

   led_pwm_multi_driver #(
      .parm_color_led_count(4), .parm_basic_led_count(4),
      .parm_FCLK(2550), .parm_pwm_freq(1), .parm_phase_step(64)
   ) u_dut1 (
      .i_clk(clk), .i_srst_n(srst_n),
      .i_color_led_red_value(red), .i_color_led_green_value(grn),
      .i_color_led_blue_value(blu), .i_basic_led_lumin_value(bas),
      .o_color_led_red(r1), .o_color_led_green(g1), .o_color_led_blue(b1),
      .o_basic_led_lumin(l1), .o_period_strobe(st1)
   );

   int total = 0;
   int bad   = 0;

   // Reference state: clocks since reset release and the shadow contents.
   int          cyc = 0;
   logic [31:0] sh_r = '0, sh_g = '0, sh_b = '0, sh_l = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_pins(input int cnt, input int stepv, input logic [31:0] sh);
      logic [3:0] p;
      p = '0;
      for (int k = 0; k < 4; k++) begin
         p[k] = (((cnt + (k * stepv) % 255) % 255) < int'(sh[8*k +: 8]));
      end
      return p;
   endfunction

   // One clock: model the edge, compare every output, then return at negedge to drive inputs.
   task automatic step();
      int         cnt;
      logic       es;
      logic [3:0] er0, eg0, eb0, el0, er1, eg1, eb1, el1;
      @(posedge clk);
      #1;
      es = 1'b0;
      {er0, eg0, eb0, el0, er1, eg1, eb1, el1} = '0;
      if (!srst_n) begin
         cyc = 0;
         sh_r = '0; sh_g = '0; sh_b = '0; sh_l = '0;
      end else begin
         cnt = (cyc / 10 == 0) ? 254 : ((cyc / 10 - 1) % 255);
         er0 = exp_pins(cnt, 0, sh_r);  er1 = exp_pins(cnt, 64, sh_r);
         eg0 = exp_pins(cnt, 0, sh_g);  eg1 = exp_pins(cnt, 64, sh_g);
         eb0 = exp_pins(cnt, 0, sh_b);  eb1 = exp_pins(cnt, 64, sh_b);
         el0 = exp_pins(cnt, 0, sh_l);  el1 = exp_pins(cnt, 64, sh_l);
         cyc++;
         es = (cyc % 10 == 0) && (cnt == 254);
         if (es) begin
            sh_r = red; sh_g = grn; sh_b = blu; sh_l = bas;
         end
      end
      check_eq("red0", 32'(r0), 32'(er0));   check_eq("red1", 32'(r1), 32'(er1));
      check_eq("grn0", 32'(g0), 32'(eg0));   check_eq("grn1", 32'(g1), 32'(eg1));
      check_eq("blu0", 32'(b0), 32'(eb0));   check_eq("blu1", 32'(b1), 32'(eb1));
      check_eq("lum0", 32'(l0), 32'(el0));   check_eq("lum1", 32'(l1), 32'(el1));
      check_eq("stb0", 32'(st0), 32'(es));   check_eq("stb1", 32'(st1), 32'(es));
      @(negedge clk);
   endtask

   task automatic wait_strobe(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!st0 && n < 3000);
      check_eq("strobe_seen", 32'(st0), 32'd1);
   endtask

   initial begin
      int n;
      int h_r0, h_r1, h_r2, h_g0, h_l3, n_st, st_pos;
      int h1 [4];

      srst_n = 1'b0;
      red = 32'hFFFF_FFFF; grn = 32'hFFFF_FFFF; blu = 32'hFFFF_FFFF; bas = 32'hFFFF_FFFF;
      @(negedge clk);
      repeat (5) step();
      check_eq("rst_outs", 32'({r0, g0, b0, l0, r1, g1, b1, l1}), 32'd0);

      srst_n = 1'b1;
      wait_strobe(n);
      check_eq("first_strobe_lat", 32'(n), 32'd10);
      step();
      check_eq("red_rise", 32'(r0), 32'hF);

      // Duty extremes and a mid-period green update, no stagger.
      red = 32'h40_80_FF_00; grn = 32'h0000_0040; blu = 32'h1020_3040; bas = 32'h0100_0000;
      wait_strobe(n);
      for (int w = 0; w < 2; w++) begin
         h_r0 = 0; h_r1 = 0; h_r2 = 0; h_g0 = 0; h_l3 = 0; n_st = 0; st_pos = 0;
         for (int j = 1; j <= 2550; j++) begin
            step();
            if (w == 0 && j == 1000) grn = 32'h0000_00C0;
            h_r0 += int'(r0[0]); h_r1 += int'(r0[1]); h_r2 += int'(r0[2]);
            h_g0 += int'(g0[0]); h_l3 += int'(l0[3]);
            if (st0) begin n_st++; st_pos = j; end
         end
         check_eq("hi_red0", 32'(h_r0), 32'd0);
         check_eq("hi_red1", 32'(h_r1), 32'd2550);
         check_eq("hi_red2", 32'(h_r2), 32'd1280);
         check_eq("hi_grn0", 32'(h_g0), (w == 0) ? 32'd640 : 32'd1920);
         check_eq("hi_lum3", 32'(h_l3), 32'd10);
         check_eq("strobe_cnt", 32'(n_st), 32'd1);
         check_eq("strobe_pos", 32'(st_pos), 32'd2550);
      end

      // Stagger: equal duty on every red pin, high time independent of offset.
      red = 32'h8080_8080;
      wait_strobe(n);
      for (int k = 0; k < 4; k++) h1[k] = 0;
      for (int j = 1; j <= 2550; j++) begin
         step();
         for (int k = 0; k < 4; k++) h1[k] += int'(r1[k]);
      end
      for (int k = 0; k < 4; k++) check_eq("hi_stagger", 32'(h1[k]), 32'd1280);

      // Reset in the middle of a period.
      wait_strobe(n);
      repeat (1500) step();
      srst_n = 1'b0;
      step();
      check_eq("rst_mid_outs", 32'({r0, g0, b0, l0, r1, g1, b1, l1, st0, st1}), 32'd0);
      srst_n = 1'b1;
      wait_strobe(n);
      check_eq("restart_lat", 32'(n), 32'd10);

      // Random input churn and occasional reset pulses against the model.
      for (int i = 0; i < 25000; i++) begin
         if ($urandom_range(0, 199) == 0) red = $urandom;
         if ($urandom_range(0, 199) == 0) grn = $urandom;
         if ($urandom_range(0, 199) == 0) blu = $urandom;
         if ($urandom_range(0, 199) == 0) bas = $urandom;
         srst_n = ($urandom_range(0, 4999) != 0);
         step();
      end
      srst_n = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
